// File: rtl/rs_gb_scheduler.sv
// ---------------------------------------------------------------------------
// rs_gb_scheduler
//   Read sequencer for the row-stationary global buffer. A start request in
//   IDLE streams every weight address, then every fmap address, to the PE
//   array over a valid/ready handshake. It then waits for the PE array to
//   report completion and emits a one-cycle done pulse.
//
//   Ports
//     clk, rst_n    clock (rising edge), asynchronous active-low reset
//     start         one-cycle pass request, only honoured in IDLE
//     pe_ready      PE array accepts the current buffer word this cycle
//     pe_done       PE array finished computing (only honoured in WAIT_PE)
//     cs[1:0]       buffer chip select: [0] fmaps, [1] weight
//     we[1:0]       buffer write enable, constant 0 (read-only sequencer)
//     fmaps_addr    fmap read address
//     weight_addr   weight read address
//     w_valid       weight word valid (== cs[1])
//     f_valid       fmap word valid   (== cs[0])
//     busy          a pass is in progress
//     done          one-cycle pulse when the pass completes
//     stall_cnt     (RS_SCHED_STALL_CNT_EN only) count of stalled cycles
//                   (valid && !pe_ready) in the current pass, saturating
//
//   Optional feature macro: RS_SCHED_STALL_CNT_EN
// ---------------------------------------------------------------------------
module rs_gb_scheduler #(
    parameter int FMAP_DEPTH   = 19,
    parameter int WEIGHT_DEPTH = 38,
    parameter int FADDR_W      = 5,
    parameter int WADDR_W      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pe_ready,
    input  logic               pe_done,
    output logic [1:0]         cs,
    output logic [1:0]         we,
    output logic [FADDR_W-1:0] fmaps_addr,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               w_valid,
    output logic               f_valid,
    output logic               busy,
    output logic               done
`ifdef RS_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_F,
        S_WAIT_PE,
        S_DONE
    } state_t;

    localparam logic [WADDR_W-1:0] W_LAST = WADDR_W'(WEIGHT_DEPTH - 1);
    localparam logic [FADDR_W-1:0] F_LAST = FADDR_W'(FMAP_DEPTH - 1);

    state_t               state_q,       state_d;
    logic [1:0]           cs_q,          cs_d;
    logic [FADDR_W-1:0]   fmaps_addr_q,  fmaps_addr_d;
    logic [WADDR_W-1:0]   weight_addr_q, weight_addr_d;
    logic                 busy_q,        busy_d;
    logic                 done_q,        done_d;

    // Next-state and next-output computation. All outputs are registered, so
    // cs/addr for the following cycle are decided here.
    always_comb begin
        state_d       = state_q;
        cs_d          = cs_q;
        fmaps_addr_d  = fmaps_addr_q;
        weight_addr_d = weight_addr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_LOAD_W;
                    cs_d          = 2'b10;
                    weight_addr_d = '0;
                    fmaps_addr_d  = '0;
                    busy_d        = 1'b1;
                end
            end
            S_LOAD_W: begin
                if (pe_ready) begin
                    if (weight_addr_q == W_LAST) begin
                        // Switch straight from weight to fmap select so the
                        // two chip selects are never high together.
                        state_d       = S_LOAD_F;
                        cs_d          = 2'b01;
                        weight_addr_d = '0;
                        fmaps_addr_d  = '0;
                    end else begin
                        weight_addr_d = weight_addr_q + 1'b1;
                    end
                end
            end
            S_LOAD_F: begin
                if (pe_ready) begin
                    if (fmaps_addr_q == F_LAST) begin
                        state_d      = S_WAIT_PE;
                        cs_d         = 2'b00;
                        fmaps_addr_d = '0;
                    end else begin
                        fmaps_addr_d = fmaps_addr_q + 1'b1;
                    end
                end
            end
            S_WAIT_PE: begin
                if (pe_done) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here.
                state_d = S_IDLE;
            end
            default: begin
                state_d       = S_IDLE;
                cs_d          = '0;
                fmaps_addr_d  = '0;
                weight_addr_d = '0;
                busy_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cs_q          <= '0;
            fmaps_addr_q  <= '0;
            weight_addr_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cs_q          <= cs_d;
            fmaps_addr_q  <= fmaps_addr_d;
            weight_addr_q <= weight_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign cs          = cs_q;
    assign we          = '0;
    assign fmaps_addr  = fmaps_addr_q;
    assign weight_addr = weight_addr_q;
    assign w_valid     = cs_q[1];
    assign f_valid     = cs_q[0];
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef RS_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Cleared when a pass is accepted; counts handshake stalls and holds its
    // value after the pass so it can be read once done has pulsed.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start) begin
            stall_cnt_d = '0;
        end else if (cs_q != 2'b00 && !pe_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rs_gb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rs_gb_scheduler
//   Directed self-checking bench for rs_gb_scheduler. Inputs change 1 ns
//   after each rising edge; outputs are checked in the same window.
// ---------------------------------------------------------------------------
module tb_rs_gb_scheduler;

    localparam int FD = 19;
    localparam int WD = 38;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       pe_ready;
    logic       pe_done;
    logic [1:0] cs;
    logic [1:0] we;
    logic [4:0] fmaps_addr;
    logic [5:0] weight_addr;
    logic       w_valid;
    logic       f_valid;
    logic       busy;
    logic       done;
`ifdef RS_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int tests_run = 0;
    int fails     = 0;

    logic [7:0] wbank [WD];
    logic [7:0] fbank [FD];
    logic [7:0] exp_w [WD];
    logic [7:0] exp_f [FD];

    rs_gb_scheduler #(
        .FMAP_DEPTH  (FD),
        .WEIGHT_DEPTH(WD),
        .FADDR_W     (5),
        .WADDR_W     (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pe_ready   (pe_ready),
        .pe_done    (pe_done),
        .cs         (cs),
        .we         (we),
        .fmaps_addr (fmaps_addr),
        .weight_addr(weight_addr),
        .w_valid    (w_valid),
        .f_valid    (f_valid),
        .busy       (busy),
        .done       (done)
`ifdef RS_SCHED_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs the remainder of a pass with pe_ready high, then completes it.
    task automatic finish_pass(input string tag);
        int n;
        n = 0;
        pe_ready = 1'b1;
        while (cs != 2'b00 && n < 200) begin
            step();
            n++;
        end
        tests_run++;
        if (cs !== 2'b00 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_reach_wait: cs=%b busy=%b, expected cs=00 busy=1", tag, cs, busy);
        end
        pe_done = 1'b1;
        step();
        pe_done = 1'b0;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: done=%b busy=%b, expected done=1 busy=0", tag, done, busy);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        pe_ready = 1'b0;
        pe_done = 1'b0;
        #12;
        tests_run++;
        if ({cs, we, fmaps_addr, weight_addr, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_values: cs=%b we=%b fa=%0d wa=%0d busy=%b done=%b, expected all 0",
                     cs, we, fmaps_addr, weight_addr, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Abort mid-weight-load at weight_addr 10.
        pe_ready = 1'b1;
        start_pass();
        repeat (10) step();
        tests_run++;
        if (weight_addr !== 6'd10 || cs !== 2'b10) begin
            fails++;
            $display("FAIL reset_pre_addr: wa=%0d cs=%b, expected 10 10", weight_addr, cs);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({cs, we, fmaps_addr, weight_addr, busy, done, w_valid, f_valid} !== '0) begin
            fails++;
            $display("FAIL reset_async: cs=%b wa=%0d busy=%b, expected all 0 immediately",
                     cs, weight_addr, busy);
        end
        step();
        step();
        rst_n = 1'b1;
        pe_ready = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0 || cs !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle: busy=%b cs=%b, expected 0 00", busy, cs);
        end
    endtask

    task automatic test_full_stream();
        int bad_w, bad_f;
        bad_w = 0;
        bad_f = 0;
        pe_ready = 1'b1;
        start_pass();
        for (int i = 0; i < WD; i++) begin
            if (w_valid !== 1'b1 || f_valid !== 1'b0 || cs !== 2'b10 ||
                we !== 2'b00 || weight_addr !== 6'(i) || busy !== 1'b1) begin
                bad_w++;
                if (bad_w == 1)
                    $display("FAIL stream_w[%0d]: wa=%0d cs=%b we=%b busy=%b, expected wa=%0d cs=10 we=00 busy=1",
                             i, weight_addr, cs, we, busy, i);
            end
            step();
        end
        tests_run++;
        if (bad_w != 0) fails++;
        for (int i = 0; i < FD; i++) begin
            if (f_valid !== 1'b1 || w_valid !== 1'b0 || cs !== 2'b01 ||
                we !== 2'b00 || fmaps_addr !== 5'(i) || weight_addr !== 6'd0) begin
                bad_f++;
                if (bad_f == 1)
                    $display("FAIL stream_f[%0d]: fa=%0d wa=%0d cs=%b we=%b, expected fa=%0d wa=0 cs=01 we=00",
                             i, fmaps_addr, weight_addr, cs, we, i);
            end
            step();
        end
        tests_run++;
        if (bad_f != 0) fails++;
        tests_run++;
        if (cs !== 2'b00 || busy !== 1'b1 || fmaps_addr !== 5'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL stream_wait: cs=%b busy=%b fa=%0d done=%b, expected 00 1 0 0",
                     cs, busy, fmaps_addr, done);
        end
        finish_pass("stream");
    endtask

    task automatic test_stall();
        int n;
        int bad;
        bad = 0;
        pe_ready = 1'b1;
        start_pass();
        repeat (5) step();
        pe_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (weight_addr !== 6'd5 || w_valid !== 1'b1) bad++;
            step();
        end
        tests_run++;
        if (bad != 0 || weight_addr !== 6'd5 || w_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_hold: wa=%0d w_valid=%b, expected 5 1", weight_addr, w_valid);
        end
        pe_ready = 1'b1;
        n = 0;
        while (cs != 2'b00 && n < 200) begin
            step();
            n++;
        end
        // Addresses 5..37 then 0..18 remain: 33 + 19 transfer cycles.
        tests_run++;
        if (n != 52) begin
            fails++;
            $display("FAIL stall_len: %0d cycles to WAIT_PE, expected 52", n);
        end
        finish_pass("stall");
`ifdef RS_SCHED_STALL_CNT_EN
        tests_run++;
        if (stall_cnt !== 16'd4) begin
            fails++;
            $display("FAIL stall_cnt: %0d, expected 4", stall_cnt);
        end
`endif
    endtask

    task automatic test_pe_done();
        pe_ready = 1'b1;
        start_pass();
        repeat (WD) step();
        pe_done = 1'b1;
        step();
        pe_done = 1'b0;
        tests_run++;
        if (f_valid !== 1'b1 || fmaps_addr !== 5'd1 || done !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pe_done_ignored: f_valid=%b fa=%0d done=%b busy=%b, expected 1 1 0 1",
                     f_valid, fmaps_addr, done, busy);
        end
        repeat (FD - 1) step();
        repeat (3) step();
        tests_run++;
        if (cs !== 2'b00 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL pe_done_wait: cs=%b busy=%b done=%b, expected 00 1 0", cs, busy, done);
        end
        pe_done = 1'b1;
        step();
        pe_done = 1'b0;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL pe_done_pulse: done=%b busy=%b, expected 1 0", done, busy);
        end
        step();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || cs !== 2'b00) begin
            fails++;
            $display("FAIL pe_done_one_cycle: done=%b busy=%b cs=%b, expected 0 0 00", done, busy, cs);
        end
    endtask

    task automatic test_start_ignored();
        pe_ready = 1'b1;
        start_pass();
        repeat (WD) step();
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (cs !== 2'b01 || fmaps_addr !== 5'd1 || weight_addr !== 6'd0) begin
            fails++;
            $display("FAIL start_in_loadf: cs=%b fa=%0d wa=%0d, expected 01 1 0", cs, fmaps_addr, weight_addr);
        end
        repeat (FD - 1) step();
        pe_done = 1'b1;
        step();
        pe_done = 1'b0;
        tests_run++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL start_done_cycle: done=%b, expected 1", done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0 || cs !== 2'b00) begin
            fails++;
            $display("FAIL start_in_done: busy=%b cs=%b, expected 0 00", busy, cs);
        end
        start_pass();
        tests_run++;
        if (busy !== 1'b1 || cs !== 2'b10 || weight_addr !== 6'd0) begin
            fails++;
            $display("FAIL start_restart: busy=%b cs=%b wa=%0d, expected 1 10 0", busy, cs, weight_addr);
        end
        finish_pass("restart");
    endtask

    task automatic test_back_to_back();
        for (int pass = 0; pass < 2; pass++) begin
            int widx, fidx, stalls, cyc, bad;
            widx = 0; fidx = 0; stalls = 0; cyc = 0; bad = 0;
            start_pass();
            do begin
                pe_ready = ((cyc % 3) != 2);
                if (cs === 2'b11) bad++;
                if (w_valid && pe_ready) begin
                    if (widx >= WD || wbank[weight_addr] !== exp_w[widx]) bad++;
                    widx++;
                end
                if (f_valid && pe_ready) begin
                    if (fidx >= FD || fbank[fmaps_addr] !== exp_f[fidx]) bad++;
                    fidx++;
                end
                if ((w_valid || f_valid) && !pe_ready) stalls++;
                step();
                cyc++;
            end while (cs != 2'b00 && cyc < 400);
            tests_run++;
            if (bad != 0 || widx != WD || fidx != FD) begin
                fails++;
                $display("FAIL b2b_data pass%0d: %0d bad words, %0d weight + %0d fmap delivered, expected 0, %0d + %0d",
                         pass, bad, widx, fidx, WD, FD);
            end
            pe_ready = 1'b0;
            pe_done = 1'b1;
            step();
            pe_done = 1'b0;
            tests_run++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL b2b_done pass%0d: done=%b busy=%b, expected 1 0", pass, done, busy);
            end
`ifdef RS_SCHED_STALL_CNT_EN
            tests_run++;
            if (stall_cnt !== 16'(stalls)) begin
                fails++;
                $display("FAIL b2b_stall_cnt pass%0d: %0d, expected %0d", pass, stall_cnt, stalls);
            end
`endif
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < WD; i++) begin
            wbank[i] = 8'(i * 7 + 3);
            exp_w[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < FD; i++) begin
            fbank[i] = 8'hC0 ^ 8'(i);
            exp_f[i] = 8'hC0 ^ 8'(i);
        end
        test_reset();
        test_full_stream();
        test_stall();
        test_pe_done();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
